// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Purpose  : N-way set-associative instruction cache between the IF stage
//            and the memory allocator. Misses refill a whole line, one word
//            per allocator transaction in ascending order, and the fetched
//            word is returned once the line is complete. Round-robin
//            replacement per set, whole-cache invalidate, and branch-flush
//            abort with drain of an in-flight word.
// Ports    : clk_in/rst_n_in (async active-low), rdy_in global hold,
//            if_*  : fetch request/response to the IF stage,
//            mem_* : single-word read channel to the allocator,
//            clear_branch_in : abort current fetch,
//            invalidate_in   : clear all valid bits.
// Options  : ICACHE_PERF_EN adds hit_cnt_out / miss_cnt_out (saturating).
// Revision : 1.0 - initial release
// ============================================================================
module icache_assoc #(
  parameter int ADDR_W     = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_a_in,
  output logic              if_valid_out,
  output logic [31:0]       if_d_out,
  output logic              if_busy_out,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_a_out,
  input  logic              mem_gr_in,
  input  logic              mem_valid_in,
  input  logic [31:0]       mem_d_in,
  input  logic              clear_branch_in,
  input  logic              invalidate_in
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]       hit_cnt_out,
  output logic [31:0]       miss_cnt_out
`endif
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t r_state, w_state_nxt;

  // Storage: data and tags are not reset, only valid bits and rr pointers.
  logic [31:0]      r_data  [SETS][WAYS][LINE_WORDS];
  logic [TAG_W-1:0] r_tag   [SETS][WAYS];
  logic [WAYS-1:0]  r_valid [SETS];
  logic [WAY_W-1:0] r_rr    [SETS];

  // Miss context latched in IDLE
  logic [TAG_W-1:0] r_tag_l;
  logic [IDX_W-1:0] r_idx_l;
  logic [OFF_W-1:0] r_off_l;
  logic [WAY_W-1:0] r_way_l;
  logic [OFF_W-1:0] r_cnt;
  logic             r_ifv;

  logic [OFF_W-1:0] w_off;
  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_hit, w_inv_found;
  logic [WAY_W-1:0] w_hit_way, w_inv_way, w_victim;
  logic             w_accept;
  logic             w_last;
  logic             w_unused_lsb;

  assign w_off        = if_a_in[OFF_W+1:2];
  assign w_idx        = if_a_in[OFF_W+IDX_W+1:OFF_W+2];
  assign w_tag        = if_a_in[ADDR_W-1:OFF_W+IDX_W+2];
  assign w_unused_lsb = ^if_a_in[1:0];

  assign w_accept = (r_state == S_IDLE) && if_req_in && !clear_branch_in;
  assign w_last   = (r_cnt == OFF_W'(LINE_WORDS - 1));

  // Tag compare, and lowest-numbered invalid way for victim selection
  always_comb begin
    w_hit       = 1'b0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(w);
      end
    end
    w_victim = w_inv_found ? w_inv_way : r_rr[w_idx];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_hit) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        if (clear_branch_in)  w_state_nxt = mem_gr_in ? S_DRAIN : S_IDLE;
        else if (mem_gr_in)   w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // A word arriving together with the flush is itself the drained word
        if (mem_valid_in) begin
          if (clear_branch_in || w_last) w_state_nxt = S_IDLE;
          else                           w_state_nxt = S_REQ;
        end else if (clear_branch_in) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_valid_in) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= S_IDLE;
      r_ifv    <= 1'b0;
      if_d_out <= '0;
      r_tag_l  <= '0;
      r_idx_l  <= '0;
      r_off_l  <= '0;
      r_way_l  <= '0;
      r_cnt    <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_rr[s]    <= '0;
      end
    end else if (rdy_in) begin
      r_state <= w_state_nxt;
      r_ifv   <= 1'b0;
      if (invalidate_in) begin
        for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
      end
      if (w_accept) begin
        if (w_hit) begin
          r_ifv    <= 1'b1;
          if_d_out <= r_data[w_idx][w_hit_way][w_off];
        end else begin
          r_tag_l <= w_tag;
          r_idx_l <= w_idx;
          r_off_l <= w_off;
          r_way_l <= w_victim;
          r_cnt   <= '0;
          r_valid[w_idx][w_victim] <= 1'b0;
          if (!w_inv_found && (WAYS > 1)) r_rr[w_idx] <= r_rr[w_idx] + 1'b1;
        end
      end
      if ((r_state == S_WAIT) && mem_valid_in && !clear_branch_in) begin
        if (r_cnt == r_off_l) if_d_out <= mem_d_in;
        if (w_last) begin
          // Placed after the invalidate loop so a completing line survives it
          r_valid[r_idx_l][r_way_l] <= 1'b1;
          r_ifv <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rdy_in && (r_state == S_WAIT) && mem_valid_in && !clear_branch_in) begin
      r_data[r_idx_l][r_way_l][r_cnt] <= mem_d_in;
      if (w_last) r_tag[r_idx_l][r_way_l] <= r_tag_l;
    end
  end

  assign if_valid_out = r_ifv && !clear_branch_in;
  assign if_busy_out  = (r_state != S_IDLE);
  assign mem_req_out  = (r_state == S_REQ);
  assign mem_a_out    = {r_tag_l, r_idx_l, r_cnt, 2'b00};

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (rdy_in && w_accept) begin
      if (w_hit) begin
        if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
      end else begin
        if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_out  = r_hit_cnt;
  assign miss_cnt_out = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_assoc
// Purpose  : Directed self-checking bench for icache_assoc (default params,
//            16-byte lines, idx = a[7:4]). Memory contents come from the
//            mem_word() model below.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_assoc;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        if_req_in;
  logic [31:0] if_a_in;
  logic        if_valid_out;
  logic [31:0] if_d_out;
  logic        if_busy_out;
  logic        mem_req_out;
  logic [31:0] mem_a_out;
  logic        mem_gr_in;
  logic        mem_valid_in;
  logic [31:0] mem_d_in;
  logic        clear_branch_in;
  logic        invalidate_in;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt_out;
  logic [31:0] miss_cnt_out;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  icache_assoc dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    .if_req_in       (if_req_in),
    .if_a_in         (if_a_in),
    .if_valid_out    (if_valid_out),
    .if_d_out        (if_d_out),
    .if_busy_out     (if_busy_out),
    .mem_req_out     (mem_req_out),
    .mem_a_out       (mem_a_out),
    .mem_gr_in       (mem_gr_in),
    .mem_valid_in    (mem_valid_in),
    .mem_d_in        (mem_d_in),
    .clear_branch_in (clear_branch_in),
    .invalidate_in   (invalidate_in)
`ifdef ICACHE_PERF_EN
    ,
    .hit_cnt_out     (hit_cnt_out),
    .miss_cnt_out    (miss_cnt_out)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Backing memory: 0x1000..0x100C -> 0xA0..0xA3, other lines offset by 0x100 per line
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] base;
    base = ({20'd0, a[15:4]} - 32'h100) << 8;
    return base + 32'hA0 + {30'd0, a[3:2]};
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int k;
    k = 0;
    while (!mem_req_out && k < 20) begin
      tick();
      k++;
    end
    check({tag, "_req_seen"}, (k < 20), 1);
  endtask

  task automatic fetch_hit(input string tag, input logic [31:0] a);
    if_req_in = 1'b1;
    if_a_in   = a;
    tick();
    if_req_in = 1'b0;
    check({tag, "_valid"}, if_valid_out, 1);
    check({tag, "_data"},  if_d_out, mem_word({a[31:2], 2'b00}));
    check({tag, "_noreq"}, mem_req_out, 0);
  endtask

  // Full line refill; checks address order, no early response, 1-cycle response
  task automatic fetch_miss(input string tag, input logic [31:0] a);
    logic [31:0] wa;
    if_req_in = 1'b1;
    if_a_in   = a;
    tick();
    if_req_in = 1'b0;
    check({tag, "_nohit"}, if_valid_out, 0);
    for (int w = 0; w < 4; w++) begin
      wa = {a[31:4], 4'h0} + 32'(w * 4);
      wait_req(tag);
      check({tag, "_addr"}, mem_a_out, wa);
      mem_gr_in = 1'b1;
      tick();
      mem_gr_in    = 1'b0;
      check({tag, "_req_drop"}, mem_req_out, 0);
      mem_valid_in = 1'b1;
      mem_d_in     = mem_word(wa);
      tick();
      mem_valid_in = 1'b0;
      if (w < 3) check({tag, "_early"}, if_valid_out, 0);
    end
    check({tag, "_rsp_valid"}, if_valid_out, 1);
    check({tag, "_rsp_data"},  if_d_out, mem_word({a[31:2], 2'b00}));
    check({tag, "_idle"},      if_busy_out, 0);
    tick();
    check({tag, "_pulse"}, if_valid_out, 0);
  endtask

  initial begin
    rst_n_in        = 1'b0;
    rdy_in          = 1'b1;
    if_req_in       = 1'b0;
    if_a_in         = '0;
    mem_gr_in       = 1'b0;
    mem_valid_in    = 1'b0;
    mem_d_in        = '0;
    clear_branch_in = 1'b0;
    invalidate_in   = 1'b0;
    tick();
    tick();
    check("rst_valid", if_valid_out, 0);
    check("rst_busy",  if_busy_out, 0);
    check("rst_req",   mem_req_out, 0);
    check("rst_addr",  mem_a_out, 0);
    rst_n_in = 1'b1;
    tick();

    // Cold miss with critical word at offset 2, then a hit in the same line
    fetch_miss("cold", 32'h0000_1008);
    fetch_hit("hit100c", 32'h0000_100C);

    // Second way, then eviction by round-robin
    fetch_miss("fill1100", 32'h0000_1100);
    fetch_hit("hit1000", 32'h0000_1000);
    fetch_hit("hit1100", 32'h0000_1100);
    fetch_miss("evict1200", 32'h0000_1200);
    fetch_hit("keep1100", 32'h0000_1100);
    fetch_miss("gone1000", 32'h0000_1000);

    // Flush with a simultaneous request in IDLE: request dropped
    if_req_in       = 1'b1;
    if_a_in         = 32'h0000_1000;
    clear_branch_in = 1'b1;
    tick();
    if_req_in       = 1'b0;
    clear_branch_in = 1'b0;
    check("flush_idle_valid", if_valid_out, 0);
    check("flush_idle_busy",  if_busy_out, 0);

    // Flush while waiting for word 1 -> DRAIN, word dropped, line stays invalid
    if_req_in = 1'b1;
    if_a_in   = 32'h0000_2040;
    tick();
    if_req_in = 1'b0;
    mem_gr_in = 1'b1;
    tick();
    mem_gr_in    = 1'b0;
    mem_valid_in = 1'b1;
    mem_d_in     = mem_word(32'h0000_2040);
    tick();
    mem_valid_in = 1'b0;
    wait_req("flush_w1");
    check("flush_w1_addr", mem_a_out, 32'h0000_2044);
    mem_gr_in = 1'b1;
    tick();
    mem_gr_in       = 1'b0;
    clear_branch_in = 1'b1;
    tick();
    clear_branch_in = 1'b0;
    check("drain_busy", if_busy_out, 1);
    check("drain_req",  mem_req_out, 0);
    mem_valid_in = 1'b1;
    mem_d_in     = mem_word(32'h0000_2044);
    tick();
    mem_valid_in = 1'b0;
    check("drain_done_busy",  if_busy_out, 0);
    check("drain_done_valid", if_valid_out, 0);
    fetch_miss("after_flush", 32'h0000_2040);

    // Invalidate: fresh reset so the perf counters start from zero
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
    fetch_miss("inv_fill", 32'h0000_1000);
    fetch_hit("inv_hit", 32'h0000_1000);
    invalidate_in = 1'b1;
    tick();
    invalidate_in = 1'b0;
    fetch_miss("inv_miss", 32'h0000_1000);
`ifdef ICACHE_PERF_EN
    check("perf_hits",   hit_cnt_out, 1);
    check("perf_misses", miss_cnt_out, 2);
`endif

    // rdy_in low holds REQ even with a grant offered
    if_req_in = 1'b1;
    if_a_in   = 32'h0000_3000;
    tick();
    if_req_in = 1'b0;
    rdy_in    = 1'b0;
    mem_gr_in = 1'b1;
    tick();
    check("rdy_hold_req",  mem_req_out, 1);
    check("rdy_hold_addr", mem_a_out, 32'h0000_3000);
    mem_gr_in = 1'b0;
    rdy_in    = 1'b1;

    // Asynchronous reset in the middle of REQ
    #2;
    rst_n_in = 1'b0;
    #1;
    check("arst_req",   mem_req_out, 0);
    check("arst_busy",  if_busy_out, 0);
    check("arst_valid", if_valid_out, 0);
    tick();
    rst_n_in = 1'b1;
    tick();
    fetch_miss("post_rst", 32'h0000_1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
- Parametrised N-way set-associative instruction cache between the IF stage and the memory allocator.
- Multi-word lines are refilled by a miss FSM, one word per allocator transaction, in ascending address order.
- Round-robin replacement per set, whole-cache invalidate, and branch-flush abort with drain of any in-flight word.
- Supersedes the direct-mapped, one-instruction-per-entry cache.

Parameters:
- ADDR_W, 32, fetch address width.
- SETS, 16, number of sets (power of 2, ≥2).
- WAYS, 2, associativity (power of 2, 1..8).
- LINE_WORDS, 4, 32-bit instructions per line (power of 2, ≥2).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- rdy_in  in  1  global enable; when low, all state is held.
- if_req_in  in  1  fetch request, pulsed for one cycle while the cache is idle.
- if_a_in  in  ADDR_W  fetch address; bits [1:0] ignored.
- if_valid_out  out  1  one-cycle pulse; if_d_out is valid.
- if_d_out  out  32  fetched instruction.
- if_busy_out  out  1  high outside IDLE; IF must not request while it is high.
- mem_req_out  out  1  word read request to the allocator.
- mem_a_out  out  ADDR_W  word address, always 4-aligned.
- mem_gr_in  in  1  allocator grant; request accepted this cycle.
- mem_valid_in  in  1  requested word returned.
- mem_d_in  in  32  returned word.
- clear_branch_in  in  1  flush: abort the current fetch.
- invalidate_in  in  1  clear all valid bits (fence.i).

Behaviour:
- Address split: off = a[log2(LINE_WORDS)+1:2]; idx = next log2(SETS) bits; tag = remaining upper bits.
- Reset (async, rst_n_in=0):
  - all valid bits, round-robin pointers and outputs = 0.
  - state = IDLE.
  - mem_a_out = 0.
- States: IDLE, REQ, WAIT, DRAIN.
- IDLE, if_req_in=1:
  - Tag compare across all ways of the set.
  - Hit: next cycle if_valid_out=1 with the word; stay IDLE. Hit latency is 1 cycle.
  - Miss: latch the address.
    - Victim = lowest-numbered invalid way; otherwise rr[idx]. Advance rr[idx] (mod WAYS) only when the victim is not an invalid way.
    - Clear the victim's valid bit; word counter = 0; go to REQ.
- REQ:
  - mem_req_out=1, mem_a_out = {tag, idx, counter, 2'b00}.
  - On mem_gr_in: drop mem_req_out next cycle; go to WAIT.
- WAIT, on mem_valid_in:
  - Write the word into victim[counter].
  - If counter == off, capture it for the response.
  - If counter == LINE_WORDS-1: set victim valid, write tag, pulse if_valid_out with the captured word next cycle, go to IDLE.
  - Otherwise: counter+1, go to REQ.
- The response is delivered only after the full line is written, so no partial-line hits are possible.
- clear_branch_in (highest priority except reset):
  - if_valid_out forced 0 that cycle.
  - IDLE with a simultaneous request: request dropped.
  - REQ before grant: mem_req_out dropped; go to IDLE.
  - REQ with simultaneous grant, or WAIT: go to DRAIN.
  - Victim line is left invalid in every case.
- DRAIN: wait for mem_valid_in, discard the word, go to IDLE. if_busy_out stays high.
- invalidate_in:
  - Clears all valid bits next cycle; rr pointers are kept.
  - Allowed in any state. During a refill the in-progress line still completes and becomes valid.
- if_req_in while if_busy_out=1 is ignored.
- rdy_in=0: no state, counter or output change; mem_valid_in is not sampled (the allocator holds it).
- Set/way arrays are not reset; only the valid bits are.

Optional Feature:
- Macro ICACHE_PERF_EN.
- Defined: adds outputs hit_cnt_out[31:0] and miss_cnt_out[31:0].
  - Incremented on each IDLE hit or miss decision, saturating at 0xFFFFFFFF.
  - Reset to 0.
  - Not cleared by invalidate or flush.
- Undefined: these ports and their counters do not exist; behaviour is otherwise identical.

Test Plan (defaults: line = 16 B, idx = a[7:4]):
- Cold miss at 0x1008 → mem_a_out sequence 0x1000, 0x1004, 0x1008, 0x100C; returned data 0xA0..0xA3; if_valid_out once with if_d_out=0xA2, exactly 1 cycle after the 4th mem_valid_in.
- After the previous test, fetch 0x100C → if_valid_out next cycle with 0xA3; mem_req_out stays 0.
- Fill 0x1000 then 0x1100 (same set 0, both ways) → both hit. Then fetch 0x1200 → evicts way 0 (0x1000). Then 0x1100 still hits and 0x1000 misses.
- clear_branch_in asserted in WAIT for word 1 of a refill → enters DRAIN, the returned word is dropped, no if_valid_out, the same address misses afterwards.
- Hit on 0x1000, pulse invalidate_in, fetch 0x1000 again → miss, 4 memory requests; with ICACHE_PERF_EN, hit_cnt_out=1, miss_cnt_out=2.
- rst_n_in low mid-REQ → mem_req_out, if_valid_out and if_busy_out are 0 immediately (async). After release, previously filled lines miss.
